// File: rtl/if_fetch_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : if_fetch_pkg                                                      |
// | Brief  : Shared state encoding and constants for the instruction fetch.    |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package if_fetch_pkg;

    localparam logic [31:0] C_ZERO_WORD    = 32'h0000_0000;
    localparam logic        C_CHIP_ENABLE  = 1'b1;
    localparam logic [31:0] C_NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_DONE  = 2'd2
    } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_byte_asm.sv
// +----------------------------------------------------------------------------+
// | Module : if_byte_asm                                                       |
// | Brief  : Four indexed byte registers presented as one little-endian word.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_byte_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [1:0]  idx_i,
    input  logic [7:0]  wdata_i,
    output logic [31:0] word_o
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        logic [7:0] byte_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                byte_q <= 8'h00;
            end else if (we_i && (idx_i == 2'(i))) begin
                byte_q <= wdata_i;
            end
        end

        assign word_o[8*i +: 8] = byte_q;
    end

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// +----------------------------------------------------------------------------+
// | Module : if_fetch                                                          |
// | Brief  : Byte-serial instruction fetch feeding the IF/ID latch.            |
// |          Optional misaligned-PC NOP substitution: IF_MISALIGN_CHECK_EN.    |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = C_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ce,
    input  logic [5:0]        stall,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    output logic              stallreq_if
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic              inst_misalign
`endif
);

    if_state_e         state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic [31:0]       w_word;
    logic              w_req;
    logic              w_we;
    logic              w_ld_word;
`ifdef IF_MISALIGN_CHECK_EN
    logic              w_ld_nop;
    logic              misalign_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        w_ld_word = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        w_ld_nop  = 1'b0;
`endif
        // A redirect or a dropped enable abandons any partial word.
        if (flush || ((ce != C_CHIP_ENABLE) && (state_q != IF_IDLE))) begin
            state_d = IF_IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IF_IDLE: begin
                    if (ce == C_CHIP_ENABLE) begin
                        addr_d = pc;
                        cnt_d  = 2'd0;
`ifdef IF_MISALIGN_CHECK_EN
                        if (pc[1:0] != 2'b00) begin
                            state_d  = IF_DONE;
                            w_ld_nop = 1'b1;
                        end else begin
                            state_d = IF_FETCH;
                        end
`else
                        state_d = IF_FETCH;
`endif
                    end
                end
                IF_FETCH: begin
                    if (mem_ready) begin
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d   = IF_DONE;
                            w_ld_word = 1'b1;
                        end
                    end
                end
                IF_DONE: begin
                    if (!stall[1]) begin
                        state_d = IF_IDLE;
                    end
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    assign w_req = (state_q == IF_FETCH) && ce && !flush;
    assign w_we  = w_req && mem_ready;

    if_byte_asm u_byte_asm (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_we),
        .idx_i   (cnt_q),
        .wdata_i (mem_rdata),
        .word_o  (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IF_IDLE;
            cnt_q     <= 2'd0;
            addr_q    <= '0;
            inst_q    <= C_ZERO_WORD;
            inst_pc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            // The last byte bypasses its register so the word is complete in DONE.
            if (w_ld_word) begin
                inst_q    <= {mem_rdata, w_word[23:0]};
                inst_pc_q <= addr_q;
            end
`ifdef IF_MISALIGN_CHECK_EN
            else if (w_ld_nop) begin
                inst_q    <= NOP_INST;
                inst_pc_q <= pc;
            end
`endif
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (w_ld_nop) begin
            misalign_q <= 1'b1;
        end else if (w_ld_word) begin
            misalign_q <= 1'b0;
        end
    end

    assign inst_misalign = inst_valid && misalign_q;
`endif

    assign mem_req     = w_req;
    assign mem_addr    = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = (state_q == IF_DONE) && ce && !flush;
    // Gated by rst so every output reads zero while reset is held.
    assign stallreq_if = rst && ce && (state_q != IF_DONE);

    logic w_unused;
`ifdef IF_MISALIGN_CHECK_EN
    assign w_unused = &{1'b0, stall[5:2], stall[0], w_word[31:24]};
`else
    assign w_unused = &{1'b0, stall[5:2], stall[0], w_word[31:24], NOP_INST};
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// +----------------------------------------------------------------------------+
// | Module : tb_if_fetch                                                       |
// | Brief  : Scoreboard bench for if_fetch; honours IF_MISALIGN_CHECK_EN.      |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        ce = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        stallreq_if;
`ifdef IF_MISALIGN_CHECK_EN
    logic        inst_misalign;
`endif

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .ce          (ce),
        .stall       (stall),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .stallreq_if (stallreq_if)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .inst_misalign (inst_misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          consumed = 0;
    logic        rdy_auto = 1'b0;
    logic [7:0]  mem [logic [31:0]];

    function automatic logic [7:0] mb(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    // Reference: the word at p, read little-endian, or NOP for a misaligned p.
    function automatic exp_t model(input logic [31:0] p);
        exp_t e;
        e.pc  = p;
        e.mis = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        if (p[1:0] != 2'b00) begin
            e.inst = 32'h0000_0013;
            e.mis  = 1'b1;
            return e;
        end
`endif
        e.inst = {mb(p + 32'd3), mb(p + 32'd2), mb(p + 32'd1), mb(p)};
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte-wide memory: data follows mem_addr, readiness random when enabled.
    always @(posedge clk) begin
        #1;
        mem_rdata = mb(mem_addr);
        if (rdy_auto) mem_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every presented instruction is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst && inst_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: inst=%h inst_pc=%h with no fetch outstanding", inst, inst_pc);
            end else begin
                chk("inst", 64'(inst), 64'(q[0].inst));
                chk("inst_pc", 64'(inst_pc), 64'(q[0].pc));
`ifdef IF_MISALIGN_CHECK_EN
                chk("inst_misalign", 64'(inst_misalign), 64'(q[0].mis));
`endif
                if (!stall[1]) begin
                    void'(q.pop_front());
                    consumed++;
                end
            end
        end
    end

    // Plain fetch with memory always ready; protocol checked cycle by cycle.
    task automatic fetch_check(input logic [31:0] p, input exp_t e);
        ce = 1'b1;
        pc = p;
        mem_ready = 1'b1;
        q.push_back(e);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("stallreq_c%0d", c), 64'(stallreq_if), 64'(c != 6));
            chk($sformatf("mem_req_c%0d", c), 64'(mem_req), 64'(c >= 2 && c <= 5));
            chk($sformatf("valid_c%0d", c), 64'(inst_valid), 64'(c == 6));
            if (c >= 2 && c <= 5) chk($sformatf("mem_addr_c%0d", c), 64'(mem_addr), 64'(p + 32'(c - 2)));
            step();
        end
        ce = 1'b0;
        step();
    endtask

    logic [31:0] held_inst;

    initial begin
        mem[32'h10] = 8'h13;
        mem[32'h11] = 8'h05;
        mem[32'h12] = 8'h10;
        mem[32'h13] = 8'h00;

        // Reset values
        ce = 1'b1;
        @(negedge clk);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_stallreq", 64'(stallreq_if), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        ce = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Single fetch with a fixed expected word
        fetch_check(32'h10, '{pc: 32'h10, inst: 32'h0010_0513, mis: 1'b0});

        // Wait states before byte 2
        ce = 1'b1;
        pc = 32'h20;
        q.push_back(model(32'h20));
        for (int c = 1; c <= 9; c++) begin
            mem_ready = !(c >= 4 && c <= 6);
            @(negedge clk);
            chk($sformatf("ws_valid_c%0d", c), 64'(inst_valid), 64'(c == 9));
            if (c >= 4 && c <= 6) begin
                chk($sformatf("ws_req_c%0d", c), 64'(mem_req), 64'd1);
                chk($sformatf("ws_addr_c%0d", c), 64'(mem_addr), 64'h22);
            end
            step();
        end
        ce = 1'b0;
        mem_ready = 1'b1;
        step();

        // Downstream stall held four cycles in DONE
        ce = 1'b1;
        pc = 32'h30;
        q.push_back(model(32'h30));
        for (int c = 1; c <= 10; c++) begin
            stall[1] = (c >= 6 && c <= 9);
            @(negedge clk);
            chk($sformatf("st_valid_c%0d", c), 64'(inst_valid), 64'(c >= 6));
            if (c >= 6) begin
                chk($sformatf("st_req_c%0d", c), 64'(mem_req), 64'd0);
                chk($sformatf("st_stallreq_c%0d", c), 64'(stallreq_if), 64'd0);
            end
            if (c == 6) held_inst = inst;
            if (c > 6) chk($sformatf("st_hold_c%0d", c), 64'(inst), 64'(held_inst));
            step();
        end
        stall[1] = 1'b0;
        ce = 1'b0;
        step();

        // Flush after byte 1, then refetch from the redirected pc
        ce = 1'b1;
        pc = 32'h40;
        q.push_back(model(32'h40));
        for (int c = 1; c <= 10; c++) begin
            flush = (c == 4);
            if (c == 4) begin
                pc = 32'h50;
                void'(q.pop_back());
                q.push_back(model(32'h50));
            end
            @(negedge clk);
            chk($sformatf("fl_valid_c%0d", c), 64'(inst_valid), 64'(c == 10));
            if (c == 4) chk("fl_req_same_cycle", 64'(mem_req), 64'd0);
            if (c >= 6 && c <= 9) chk($sformatf("fl_addr_c%0d", c), 64'(mem_addr), 64'(32'h50 + 32'(c - 6)));
            step();
        end
        flush = 1'b0;
        ce = 1'b0;
        step();

        // Asynchronous reset in the middle of FETCH
        ce = 1'b1;
        pc = 32'h60;
        q.push_back(model(32'h60));
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_mem_req", 64'(mem_req), 64'd0);
        chk("arst_mem_addr", 64'(mem_addr), 64'd0);
        chk("arst_inst", 64'(inst), 64'd0);
        chk("arst_inst_pc", 64'(inst_pc), 64'd0);
        chk("arst_valid", 64'(inst_valid), 64'd0);
        chk("arst_stallreq", 64'(stallreq_if), 64'd0);
        step();
        rst = 1'b1;
        void'(q.pop_back());
        fetch_check(32'h60, model(32'h60));

        // Top-of-memory fetch must not carry past the address width
        fetch_check(32'hFFFF_FFFC, model(32'hFFFF_FFFC));

        // Misaligned PC
`ifdef IF_MISALIGN_CHECK_EN
        ce = 1'b1;
        pc = 32'h2;
        q.push_back(model(32'h2));
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("mis_req_c%0d", c), 64'(mem_req), 64'd0);
            chk($sformatf("mis_valid_c%0d", c), 64'(inst_valid), 64'(c == 2));
            chk($sformatf("mis_flag_c%0d", c), 64'(inst_misalign), 64'(c == 2));
            step();
        end
        ce = 1'b0;
        step();
`else
        fetch_check(32'h2, model(32'h2));
`endif

        // Randomised run: the bench plays the PC register and memory
        begin
            logic adv;
            logic stopping;
            int   base;
            stopping = 1'b0;
            base = consumed;
            rdy_auto = 1'b1;
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            q.push_back(model(pc));
            ce = 1'b1;
            for (int n = 0; n < 3000; n++) begin
                @(negedge clk);
                adv = ce && !stallreq_if && !stall[1] && !flush;
                step();
                flush = 1'b0;
                if (n >= 2500) stopping = 1'b1;
                if (adv) begin
                    if (stopping) begin
                        ce = 1'b0;
                        break;
                    end
                    pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
                    if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
                    q.push_back(model(pc));
                end
                ce = 1'b1;
                stall = 6'($urandom);
                stall[1] = ($urandom_range(0, 3) == 0);
                if (stopping) begin
                    stall[1] = 1'b0;
                end else if ($urandom_range(0, 24) == 0) begin
                    flush = 1'b1;
                    if (q.size() != 0) void'(q.pop_back());
                    pc = $urandom;
                    q.push_back(model(pc));
                end else if ($urandom_range(0, 29) == 0) begin
                    ce = 1'b0;
                end
            end
            ce = 1'b0;
            step();
            step();
            chk("random_drained", 64'(q.size()), 64'd0);
            chk("random_progress", 64'(consumed - base >= 50), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
